// File: rtl/dac_spi_tx.sv
// dac_spi_tx: captures a DDS sample on Ready, sends a 16-bit MCP4922 SPI frame (mode 0), then pulses LDACn; DAC_DUAL_CH_EN adds channel B.
// Latency: CSn low on the capture edge, Busy 36*CLK_DIV cycles (70*CLK_DIV dual); no backpressure, Ready while Busy is dropped and sets Overrun.
module dac_spi_tx #(
  parameter int DATA_W  = 32,
  parameter int DAC_W   = 12,
  parameter int CLK_DIV = 2
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Enable,
  input  logic              Ready,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic              DAC_SCLK,
  output logic              DAC_SDI,
  output logic              DAC_CSn,
  output logic              DAC_LDACn,
  output logic              Busy,
  output logic              Overrun
);

  localparam int FW = DAC_W + 4;
  localparam int BW = $clog2(FW);
  localparam int TW = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_HALF = TW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
`ifdef DAC_DUAL_CH_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LATCH} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FW-1:0]   sr, sr_nxt;
  logic            ch_b, ch_b_nxt;
  logic            hit, capture, tmr_end;
  logic            sclk_nxt, sdi_nxt, csn_nxt, ldacn_nxt, busy_nxt, ovr_nxt;
  logic            unused_bits;

  // Offset-binary code is the sample MSBs with the sign bit flipped.
  function automatic logic [FW-1:0] mk_frame(input logic chb, input logic [DAC_W-1:0] top);
    logic [DAC_W-1:0] code;
    code = top;
    code[DAC_W-1] = ~code[DAC_W-1];
    return {chb, 3'b011, code};
  endfunction

  assign hit     = Ready & Enable;
  assign capture = hit && (state == S_IDLE);
  assign tmr_end = (tmr == TMR_LAST);

`ifdef DAC_DUAL_CH_EN
  logic [FW-1:0] frame_b;

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      frame_b <= '0;
    end else if (capture) begin
      frame_b <= mk_frame(1'b1, in2[DATA_W-1 -: DAC_W]);
    end
  end

  assign unused_bits = ^{in1[DATA_W-DAC_W-1:0], in2[DATA_W-DAC_W-1:0]};
`else
  assign unused_bits = ^{in1[DATA_W-DAC_W-1:0], in2};
`endif

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (capture) state_nxt = S_SHIFT;
      S_SHIFT: if (tmr_end && (bit_cnt == BIT_LAST)) state_nxt = S_GAP;
      S_GAP:   if (tmr_end) state_nxt = (DUAL && !ch_b) ? S_SHIFT : S_LATCH;
      S_LATCH: if (tmr_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // tmr paces SCLK half-periods in SHIFT and the gap/latch widths elsewhere.
  always_comb begin
    tmr_nxt     = '0;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    ch_b_nxt    = ch_b;
    if ((state_nxt == state) && (state != S_IDLE)) begin
      tmr_nxt = tmr_end ? '0 : tmr + 1'b1;
    end
    if (capture) begin
      bit_cnt_nxt = '0;
      sr_nxt      = mk_frame(1'b0, in1[DATA_W-1 -: DAC_W]);
      ch_b_nxt    = 1'b0;
    end
`ifdef DAC_DUAL_CH_EN
    else if ((state == S_GAP) && (state_nxt == S_SHIFT)) begin
      bit_cnt_nxt = '0;
      sr_nxt      = frame_b;
      ch_b_nxt    = 1'b1;
    end
`endif
    else if ((state == S_SHIFT) && tmr_end) begin
      bit_cnt_nxt = bit_cnt + 1'b1;
      sr_nxt      = {sr[FW-2:0], 1'b0};
    end
  end

  always_comb begin
    sclk_nxt  = (state_nxt == S_SHIFT) && (tmr_nxt >= TMR_HALF);
    sdi_nxt   = (state_nxt == S_SHIFT) && sr_nxt[FW-1];
    csn_nxt   = (state_nxt != S_SHIFT);
    ldacn_nxt = (state_nxt != S_LATCH);
    busy_nxt  = (state_nxt != S_IDLE);
    ovr_nxt   = Overrun | (hit && (state != S_IDLE));
  end

  // Pins are registered so the DAC never sees decode glitches.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      tmr       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      ch_b      <= 1'b0;
      DAC_SCLK  <= 1'b0;
      DAC_SDI   <= 1'b0;
      DAC_CSn   <= 1'b1;
      DAC_LDACn <= 1'b1;
      Busy      <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      tmr       <= tmr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sr        <= sr_nxt;
      ch_b      <= ch_b_nxt;
      DAC_SCLK  <= sclk_nxt;
      DAC_SDI   <= sdi_nxt;
      DAC_CSn   <= csn_nxt;
      DAC_LDACn <= ldacn_nxt;
      Busy      <= busy_nxt;
      Overrun   <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: cycle-offset reference model plus SPI frame decoder and literal frame checks.
module tb_dac_spi_tx;

  localparam int CKD = 2;
`ifdef DAC_DUAL_CH_EN
  localparam int NFR      = 2;
  localparam int BUSY_LEN = 70 * CKD;
`else
  localparam int NFR      = 1;
  localparam int BUSY_LEN = 36 * CKD;
`endif

  logic        Fg_CLK = 1'b0;
  logic        RESETn = 1'b1;
  logic        Enable = 1'b0;
  logic        Ready  = 1'b0;
  logic [31:0] in1    = '0;
  logic [31:0] in2    = '0;
  logic        DAC_SCLK, DAC_SDI, DAC_CSn, DAC_LDACn, Busy, Overrun;

  int errors = 0;
  int checks = 0;

  // Reference state: cycles since capture (-1 = idle), sticky overrun, expected frames.
  int          mk    = -1;
  logic        m_ovr = 1'b0;
  logic [15:0] m_fa  = '0;
  logic [15:0] m_fb  = '0;

  int csn_low_total  = 0;
  int ldac_low_total = 0;
  int busy_total     = 0;

  logic [15:0] dec   = '0;
  int          dec_n = 0;
  logic [15:0] frames[$];
  int          fbits[$];

  logic [5:0] cmp_e, cmp_a, cmp_m;

  logic [31:0] v_in1 [4] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
  logic [31:0] v_in2 [4] = '{32'hC000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
  logic [15:0] v_ea  [4] = '{16'h3C00, 16'h3000, 16'h3800, 16'h3FFF};
  logic [15:0] v_eb  [4] = '{16'hB400, 16'hBFFF, 16'hB000, 16'hB800};

  dac_spi_tx #(.DATA_W(32), .DAC_W(12), .CLK_DIV(CKD)) dut (
    .Fg_CLK   (Fg_CLK),
    .RESETn   (RESETn),
    .Enable   (Enable),
    .Ready    (Ready),
    .in1      (in1),
    .in2      (in2),
    .DAC_SCLK (DAC_SCLK),
    .DAC_SDI  (DAC_SDI),
    .DAC_CSn  (DAC_CSn),
    .DAC_LDACn(DAC_LDACn),
    .Busy     (Busy),
    .Overrun  (Overrun)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  function automatic logic [15:0] spec_frame(input logic chb, input logic [31:0] s);
    return {chb, 3'b011, ~s[31], s[30:20]};
  endfunction

  // Expected pins at cycle offset k after the capture edge, from the frame timing rules.
  function automatic logic [5:0] model_out(input int k, input logic ovr,
                                           input logic [15:0] fa, input logic [15:0] fb);
    logic sclk, sdi, csn, ldacn, busy;
    int j;
    logic [15:0] f;
    sclk = 1'b0; sdi = 1'b0; csn = 1'b1; ldacn = 1'b1; busy = (k >= 0);
    j = -1;
    f = fa;
    if (k >= 0 && k < 32 * CKD) begin
      j = k;
    end else if (NFR == 2 && k >= 34 * CKD && k < 66 * CKD) begin
      j = k - 34 * CKD;
      f = fb;
    end else if (k >= BUSY_LEN - 2 * CKD) begin
      ldacn = 1'b0;
    end
    if (j >= 0) begin
      csn  = 1'b0;
      sclk = (j % (2 * CKD)) >= CKD;
      sdi  = f[15 - j / (2 * CKD)];
    end
    return {sclk, sdi, csn, ldacn, busy, ovr};
  endfunction

  always @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      mk    <= -1;
      m_ovr <= 1'b0;
    end else if (mk < 0) begin
      if (Ready && Enable) begin
        mk   <= 0;
        m_fa <= spec_frame(1'b0, in1);
        m_fb <= spec_frame(1'b1, in2);
      end
    end else begin
      if (Ready && Enable) m_ovr <= 1'b1;
      mk <= (mk + 1 >= BUSY_LEN) ? -1 : mk + 1;
    end
  end

  always @(negedge Fg_CLK) begin
    cmp_e = model_out(mk, m_ovr, m_fa, m_fb);
    cmp_a = {DAC_SCLK, DAC_SDI, DAC_CSn, DAC_LDACn, Busy, Overrun};
    cmp_m = cmp_e[3] ? 6'b101111 : 6'b111111;  // SDI is don't-care while CSn is high
    checks++;
    if ((cmp_a & cmp_m) !== (cmp_e & cmp_m)) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t k=%0d: sclk/sdi/csn/ldacn/busy/ovr got %b expected %b",
               $time, mk, cmp_a, cmp_e);
    end
    if (DAC_CSn === 1'b0)   csn_low_total++;
    if (DAC_LDACn === 1'b0) ldac_low_total++;
    if (Busy === 1'b1)      busy_total++;
  end

  always @(posedge DAC_SCLK or posedge DAC_CSn) begin
    if (DAC_CSn === 1'b1) begin
      if (dec_n > 0) begin
        frames.push_back(dec);
        fbits.push_back(dec_n);
      end
      dec_n = 0;
    end else begin
      dec   = {dec[14:0], DAC_SDI};
      dec_n = dec_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_frame(input int idx);
    if (idx >= 0 && idx < frames.size()) return {16'h0, frames[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_bits(input int idx);
    if (idx >= 0 && idx < fbits.size()) return fbits[idx];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic pulse_ready(input logic [31:0] a, input logic [31:0] b, input logic en);
    @(posedge Fg_CLK); #2;
    in1 = a; in2 = b; Enable = en; Ready = 1'b1;
    @(posedge Fg_CLK); #2;
    Ready = 1'b0;
  endtask

  task automatic do_frame(input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] ea, input logic [15:0] eb);
    int f0, c0, l0, b0;
    f0 = frames.size(); c0 = csn_low_total; l0 = ldac_low_total; b0 = busy_total;
    pulse_ready(a, b, 1'b1);
    repeat (BUSY_LEN + 4) @(posedge Fg_CLK);
    #2;
    chk("frame_count", frames.size() - f0, NFR);
    chk("frame_a", get_frame(f0), {16'h0, ea});
    chk("frame_a_bits", get_bits(f0), 16);
`ifdef DAC_DUAL_CH_EN
    chk("frame_b", get_frame(f0 + 1), {16'h0, eb});
    chk("frame_b_bits", get_bits(f0 + 1), 16);
`else
    chk("in2_ignored_frame_a_only", get_frame(f0 + 1), 32'hFFFF_FFFF);
    if (eb == 16'h0) $display("note: zero channel B literal");
`endif
    chk("csn_low_cycles", csn_low_total - c0, NFR * 32 * CKD);
    chk("ldacn_low_cycles", ldac_low_total - l0, 2 * CKD);
    chk("busy_cycles", busy_total - b0, BUSY_LEN);
  endtask

  initial begin
    int f0, b0;

    #1 RESETn = 1'b0;
    repeat (5) @(posedge Fg_CLK);
    #2; Enable = 1'b1; Ready = 1'b1; in1 = 32'h4000_0000;
    @(posedge Fg_CLK); #2; Ready = 1'b0;
    repeat (4) @(posedge Fg_CLK);
    @(negedge Fg_CLK); #1;
    chk("reset_values", {26'h0, DAC_SCLK, DAC_SDI, DAC_CSn, DAC_LDACn, Busy, Overrun}, 32'b001100);
    f0 = frames.size(); b0 = busy_total;
    @(posedge Fg_CLK); #2; RESETn = 1'b1;
    repeat (6) @(posedge Fg_CLK);
    chk("no_frame_from_reset_ready", frames.size() - f0, 0);
    chk("no_busy_from_reset_ready", busy_total - b0, 0);

    for (int i = 0; i < 4; i++) do_frame(v_in1[i], v_in2[i], v_ea[i], v_eb[i]);

    // Ready with Enable low while idle is ignored.
    f0 = frames.size(); b0 = busy_total;
    pulse_ready(32'h4000_0000, 32'hC000_0000, 1'b0);
    repeat (10) @(posedge Fg_CLK);
    chk("enable_low_no_frame", frames.size() - f0, 0);
    chk("enable_low_no_busy", busy_total - b0, 0);
    chk("enable_low_no_overrun", Overrun, 0);

    // Enable drops after capture; a disabled Ready mid-frame is not an overrun.
    f0 = frames.size(); b0 = busy_total;
    pulse_ready(32'h0000_0000, 32'h8000_0000, 1'b1);
    Enable = 1'b0;
    repeat (8) @(posedge Fg_CLK);
    pulse_ready(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    repeat (BUSY_LEN) @(posedge Fg_CLK);
    chk("enable_drop_frame_count", frames.size() - f0, NFR);
    chk("enable_drop_frame_a", get_frame(f0), 32'h3800);
    chk("enable_drop_busy", busy_total - b0, BUSY_LEN);
    chk("enable_drop_no_overrun", Overrun, 0);
    Enable = 1'b1;

    // Overrun: second valid Ready 20 cycles after capture.
    f0 = frames.size(); b0 = busy_total;
    pulse_ready(32'h8000_0000, 32'h4000_0000, 1'b1);
    repeat (18) @(posedge Fg_CLK);
    pulse_ready(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (2) @(posedge Fg_CLK);
    chk("overrun_set", Overrun, 1);
    repeat (BUSY_LEN + 4) @(posedge Fg_CLK);
    chk("overrun_frame_count", frames.size() - f0, NFR);
    chk("overrun_frame_a", get_frame(f0), 32'h3000);
    chk("overrun_busy", busy_total - b0, BUSY_LEN);
    chk("overrun_sticky", Overrun, 1);

    // Reset at the start of bit 8 aborts the frame at once.
    pulse_ready(32'h4000_0000, 32'hC000_0000, 1'b1);
    repeat (32) @(posedge Fg_CLK);
    #2; RESETn = 1'b0;
    #1;
    chk("midreset_csn", DAC_CSn, 1);
    chk("midreset_sclk", DAC_SCLK, 0);
    chk("midreset_busy", Busy, 0);
    chk("midreset_overrun_cleared", Overrun, 0);
    chk("midreset_partial_bits", get_bits(fbits.size() - 1), 8);
    repeat (3) @(posedge Fg_CLK);
    #2; RESETn = 1'b1;
    do_frame(32'h4000_0000, 32'hC000_0000, 16'h3C00, 16'hB400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

DDS sample sink: captures each oscillator sample on the `Ready` strobe, converts it from signed 32-bit to a 12-bit offset-binary DAC code and shifts it out as a 16-bit SPI frame to an external MCP4922-class DAC, followed by a latch (`LDACn`) pulse. Sits downstream of `oscillator`/`sampling_control`, sharing `Fg_CLK` (24 MHz) and `RESETn`, and drives the board DAC pins.

## Interface
- `DATA_W`, 32, width of oscillator sample inputs
- `DAC_W`, 12, DAC code width; taken from sample MSBs
- `CLK_DIV`, 2, `Fg_CLK` cycles per SCLK half-period (≥1)
- `Fg_CLK`  in  1  system clock, rising-edge
- `RESETn`  in  1  reset, asynchronous, active-low
- `Enable`  in  1  from `sampling_control`; captures allowed only when high
- `Ready`  in  1  one-cycle sample-valid strobe from `sampling_control`
- `in1`  in  DATA_W  channel A sample (`oscillator.out1`), signed two's complement
- `in2`  in  DATA_W  channel B sample (`oscillator.out2`); used only with `DAC_DUAL_CH_EN`
- `DAC_SCLK`  out  1  serial clock, idle low
- `DAC_SDI`  out  1  serial data, MSB first
- `DAC_CSn`  out  1  frame select, active-low
- `DAC_LDACn`  out  1  output latch strobe, active-low
- `Busy`  out  1  high from capture until return to IDLE
- `Overrun`  out  1  sticky: a valid `Ready` arrived while `Busy`

## Operation
- Reset values: `DAC_SCLK`=0, `DAC_SDI`=0, `DAC_CSn`=1, `DAC_LDACn`=1, `Busy`=0, `Overrun`=0, FSM=IDLE. Async reset mid-frame aborts immediately; no partial-frame recovery.
- Capture: on an `Fg_CLK` edge with FSM=IDLE, `Ready`=1 and `Enable`=1, register the samples and go to SHIFT. `Ready` with `Enable`=0 is ignored and does not set `Overrun`.
- Conversion: code = `in[DATA_W-1 -: DAC_W]` with its MSB inverted (truncation, no rounding). 0x8000_0000→0x000, 0x0000_0000→0x800, 0x7FFF_FFFF→0xFFF.
- Frame (16 bits, MSB first): {A/B, BUF=0, GA=1, SHDNn=1, code[11:0]}; header 4'b0011 for channel A, 4'b1011 for channel B.
- FSM: IDLE → SHIFT (16 bits) → GAP (CSn high) → [dual only: SHIFT channel B → GAP] → LATCH (LDACn low) → IDLE.
- Overrun: valid `Ready` while FSM≠IDLE sets `Overrun`; the sample is dropped and the current frame continues undisturbed. Cleared only by reset.
- `Enable` falling mid-frame does not abort; the frame and latch complete.

## Timing
- Capture edge (T0): `DAC_CSn`→0, `DAC_SDI`=bit15, `DAC_SCLK`=0, `Busy`→1, all registered at T0.
- Per bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. SDI changes only when SCLK falls (or at T0), so it is stable across each rising edge (SPI mode 0).
- SHIFT lasts 32·CLK_DIV cycles (64 at default). After the last high phase: SCLK→0, CSn→1.
- GAP: CSn high for 2·CLK_DIV cycles. LATCH: LDACn low for 2·CLK_DIV cycles, then IDLE with `Busy`→0.
- Single-channel `Busy` duration = 36·CLK_DIV (72 cycles at default). Dual = 70·CLK_DIV (140).
- A new capture is accepted on the first edge with FSM=IDLE. Back-to-back frames have CSn high ≥ 2·CLK_DIV cycles.

## Configuration
- `DAC_DUAL_CH_EN` defined: each capture sends channel A (`in1`), then channel B (`in2`, header 1011), then a single LDAC pulse updates both outputs together. `Busy` = 70·CLK_DIV.
- Not defined: only channel A is sent. `in2` is unused. `Busy` = 36·CLK_DIV.

## Test plan
- Reset: hold `RESETn`=0 for 10 cycles → all outputs at reset values. Pulse `Ready` while in reset → no frame.
- Single capture, default params, `in1`=32'h4000_0000 → decoded SDI frame 0x3C00 sampled on SCLK rising edges. CSn low exactly 64 cycles, LDACn low 4 cycles, `Busy` high 72 cycles.
- Code extremes: `in1`=32'h8000_0000 → 0x3000. `in1`=32'h0000_0000 → 0x3800. `in1`=32'h7FFF_FFFF → 0x3FFF.
- Overrun: second `Ready` 20 cycles after first capture → `Overrun`=1 and stays high, first frame unchanged, no second frame. A `Ready` with `Enable`=0 → no frame, `Overrun` unchanged.
- Reset mid-frame: assert `RESETn`=0 at bit 8 → CSn=1 and SCLK=0 immediately. After release, next `Ready` produces a complete correct frame.
- With `DAC_DUAL_CH_EN`, `in1`=32'h4000_0000, `in2`=32'hC000_0000 → frames 0x3C00 then 0xB400, a single LDACn pulse after the second frame, `Busy` high 140 cycles.
